// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM port arbiter: FSM state encoding and the port index type.
package sdram_arb_pkg;
    localparam int MAX_PORTS  = 8;
    localparam int PORT_IDX_W = $clog2(MAX_PORTS);

    typedef logic [PORT_IDX_W-1:0] port_idx_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } arb_state_t;
endpackage

// File: rtl/sdram_arb_picker.sv
// Combinational grant picker: first pending port at or after i_start, wrapping modulo PORT_COUNT.
module sdram_arb_picker
    import sdram_arb_pkg::*;
#(
    parameter int PORT_COUNT = 4
) (
    input  logic [PORT_COUNT-1:0] i_pend,
    input  port_idx_t             i_start,
    output logic                  o_vld,
    output port_idx_t             o_idx
);

    int w_best;
    int w_dist;

    // Smallest circular distance from i_start wins.
    always_comb begin
        o_vld  = 1'b0;
        o_idx  = '0;
        w_best = PORT_COUNT;
        w_dist = 0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            w_dist = i - int'(i_start);
            if (w_dist < 0) w_dist = w_dist + PORT_COUNT;
            if (i_pend[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_vld  = 1'b1;
                o_idx  = port_idx_t'(i);
            end
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Multi-port front end for one SDRAM controller: per-port request slots, one operation in flight.
// Round-robin grant by default; SDRAM_ARB_FIXED_PRIORITY_EN selects lowest-index-first.
module sdram_port_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int PORT_COUNT = 4,
    parameter int ADDR_WIDTH = 25,
    parameter int DATA_WIDTH = 16,
    parameter int Q_WIDTH    = 32
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 init_complete,
    input  logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] p_addr,
    input  logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] p_data,
    input  logic [PORT_COUNT-1:0][1:0]            p_byte_en,
    input  logic [PORT_COUNT-1:0]                 p_wr_req,
    input  logic [PORT_COUNT-1:0]                 p_rd_req,
    output logic [PORT_COUNT-1:0][Q_WIDTH-1:0]    p_q,
    output logic [PORT_COUNT-1:0]                 p_ready,
    output logic [ADDR_WIDTH-1:0]                 ctrl_addr,
    output logic [DATA_WIDTH-1:0]                 ctrl_data,
    output logic [1:0]                            ctrl_byte_en,
    output logic                                  ctrl_wr_req,
    output logic                                  ctrl_rd_req,
    input  logic [Q_WIDTH-1:0]                    ctrl_q,
    input  logic                                  ctrl_ready
);

    arb_state_t r_state, w_state_nxt;
    logic       r_tol, w_tol_nxt;

    logic [PORT_COUNT-1:0]                 r_pend;
    logic [PORT_COUNT-1:0]                 r_slot_wr;
    logic [PORT_COUNT-1:0][ADDR_WIDTH-1:0] r_slot_addr;
    logic [PORT_COUNT-1:0][DATA_WIDTH-1:0] r_slot_data;
    logic [PORT_COUNT-1:0][1:0]            r_slot_be;
    logic [PORT_COUNT-1:0][Q_WIDTH-1:0]    r_q;

    logic [ADDR_WIDTH-1:0] r_ctrl_addr, w_sel_addr;
    logic [DATA_WIDTH-1:0] r_ctrl_data, w_sel_data;
    logic [1:0]            r_ctrl_be, w_sel_be;
    logic                  w_sel_wr;

    port_idx_t r_gnt, w_start, w_pick_idx;
    logic      r_gnt_wr, r_alive, w_pick_vld, w_grant, w_done;

    assign w_grant = (r_state == ST_IDLE) && init_complete && ctrl_ready && w_pick_vld;
    assign w_done  = (r_state == ST_WAIT_DONE) && ctrl_ready;

`ifdef SDRAM_ARB_FIXED_PRIORITY_EN
    assign w_start = '0;
`else
    port_idx_t r_last;

    assign w_start = (r_last == port_idx_t'(PORT_COUNT - 1)) ? '0 : r_last + port_idx_t'(1);

    // Reset value makes port 0 the first one searched.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     r_last <= port_idx_t'(PORT_COUNT - 1);
        else if (w_grant) r_last <= w_pick_idx;
    end
`endif

    sdram_arb_picker #(.PORT_COUNT(PORT_COUNT)) u_picker (
        .i_pend  (r_pend),
        .i_start (w_start),
        .o_vld   (w_pick_vld),
        .o_idx   (w_pick_idx)
    );

    always_comb begin
        w_sel_wr   = 1'b0;
        w_sel_addr = '0;
        w_sel_data = '0;
        w_sel_be   = '0;
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (w_pick_idx == port_idx_t'(i)) begin
                w_sel_wr   = r_slot_wr[i];
                w_sel_addr = r_slot_addr[i];
                w_sel_data = r_slot_data[i];
                w_sel_be   = r_slot_be[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tol   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_tol   <= w_tol_nxt;
        end
    end

    // A controller that never drops ctrl_ready is tolerated for one extra cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_tol_nxt   = 1'b0;
        ctrl_wr_req = 1'b0;
        ctrl_rd_req = 1'b0;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_nxt = ST_ISSUE;
            ST_ISSUE: begin
                ctrl_wr_req = r_gnt_wr;
                ctrl_rd_req = ~r_gnt_wr;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (ctrl_ready && !r_tol) w_tol_nxt   = 1'b1;
                else                      w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: if (ctrl_ready) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_alive     <= 1'b0;
            r_pend      <= '0;
            r_slot_wr   <= '0;
            r_slot_addr <= '0;
            r_slot_data <= '0;
            r_slot_be   <= '0;
            r_q         <= '0;
            r_gnt       <= '0;
            r_gnt_wr    <= 1'b0;
            r_ctrl_addr <= '0;
            r_ctrl_data <= '0;
            r_ctrl_be   <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_grant) begin
                r_gnt       <= w_pick_idx;
                r_gnt_wr    <= w_sel_wr;
                r_ctrl_addr <= w_sel_addr;
                r_ctrl_data <= w_sel_data;
                r_ctrl_be   <= w_sel_be;
            end
            // An occupied slot ignores new requests until its completion edge.
            for (int i = 0; i < PORT_COUNT; i++) begin
                if (r_pend[i]) begin
                    if (w_done && (r_gnt == port_idx_t'(i))) begin
                        r_pend[i] <= 1'b0;
                        if (!r_gnt_wr) r_q[i] <= ctrl_q;
                    end
                end else if (p_wr_req[i] || p_rd_req[i]) begin
                    r_pend[i]      <= 1'b1;
                    r_slot_wr[i]   <= p_wr_req[i];
                    r_slot_addr[i] <= p_addr[i];
                    r_slot_data[i] <= p_data[i];
                    r_slot_be[i]   <= p_byte_en[i];
                end
            end
        end
    end

    assign p_q          = r_q;
    assign p_ready      = {PORT_COUNT{r_alive}} & ~r_pend;
    assign ctrl_addr    = r_ctrl_addr;
    assign ctrl_data    = r_ctrl_data;
    assign ctrl_byte_en = r_ctrl_be;

endmodule
